// File: rtl/multicycle_ctrl.sv
// Multicycle control unit for the ARM-subset processor: sequences the shared
// ALU, memory and register file, holds NZCV and evaluates the condition field.
module multicycle_ctrl #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Cond,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] ALUFlags,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic [1:0] ResultSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ImmSrc,
  output logic [1:0] RegSrc,
  output logic [1:0] ALUControl,
  output logic [3:0] Flags,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  // Condition field evaluated against a stored NZCV value.
  function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v;
    logic res;
    {n, z, c, v} = nzcv;
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~c | z;
      4'b1010: res = (n == v);
      4'b1011: res = (n != v);
      4'b1100: res = ~z & (n == v);
      4'b1101: res = z | (n != v);
      4'b1110: res = 1'b1;
      default: res = 1'b0;
    endcase
    return res;
  endfunction

  // Data-processing decode: {ALUControl[1:0], NoWrite, C/V update}.
  function automatic logic [3:0] alu_decode(input logic [3:0] cmd);
    logic [3:0] res;
    case (cmd)
      4'b0100: res = {2'b00, 1'b0, 1'b1};
      4'b0010: res = {2'b01, 1'b0, 1'b1};
      4'b0000: res = {2'b10, 1'b0, 1'b0};
      4'b1100: res = {2'b11, 1'b0, 1'b0};
      4'b1010: res = {2'b01, 1'b1, 1'b1};
      default: res = {2'b00, 1'b1, 1'b0};
    endcase
    return res;
  endfunction

  state_t     state_r;
  state_t     state_next_s;
  logic [3:0] flags_r;
  logic       nowrite_r;
  logic       condex_s;
  logic [3:0] dec_s;
  logic       in_execute_s;

  logic       pcwrite_s;
  logic       memwrite_s;
  logic       regwrite_s;
  logic       irwrite_s;
  logic       adrsrc_s;
  logic [1:0] resultsrc_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic [1:0] alucontrol_s;

  assign condex_s     = cond_check(Cond, flags_r);
  assign dec_s        = alu_decode(Funct[4:1]);
  assign in_execute_s = (state_r == EXECUTER) || (state_r == EXECUTEI);

  // Next-state selection; unused encodings fall back to FETCH.
  always_comb begin
    state_next_s = FETCH;
    case (state_r)
      FETCH:    state_next_s = DECODE;
      DECODE: begin
        case (Op)
          2'b01:   state_next_s = MEMADR;
          2'b00:   state_next_s = Funct[5] ? EXECUTEI : EXECUTER;
          2'b10:   state_next_s = BRANCH;
          default: state_next_s = FETCH;
        endcase
      end
      MEMADR:   state_next_s = Funct[0] ? MEMRD : MEMWR;
      MEMRD:    state_next_s = MEMWB;
      EXECUTER: state_next_s = ALUWB;
      EXECUTEI: state_next_s = ALUWB;
      default:  state_next_s = FETCH;
    endcase
  end

  // State, NZCV and NoWrite registers; flags only move at the end of EXECUTE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= FETCH;
      flags_r   <= RESET_FLAGS;
      nowrite_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      if (in_execute_s) begin
        nowrite_r <= dec_s[1];
        if (condex_s && Funct[0]) begin
          flags_r[3:2] <= ALUFlags[3:2];
          if (dec_s[0]) begin
            flags_r[1:0] <= ALUFlags[1:0];
          end else begin
            flags_r[1:0] <= flags_r[1:0];
          end
        end else begin
          flags_r <= flags_r;
        end
      end else begin
        nowrite_r <= nowrite_r;
        flags_r   <= flags_r;
      end
    end
  end

  // Moore output decode from the current state.
  always_comb begin
    pcwrite_s    = 1'b0;
    memwrite_s   = 1'b0;
    regwrite_s   = 1'b0;
    irwrite_s    = 1'b0;
    adrsrc_s     = 1'b0;
    resultsrc_s  = 2'b00;
    alusrca_s    = 1'b0;
    alusrcb_s    = 2'b00;
    alucontrol_s = 2'b00;
    case (state_r)
      FETCH: begin
        irwrite_s   = 1'b1;
        alusrca_s   = 1'b1;
        alusrcb_s   = 2'b10;
        resultsrc_s = 2'b10;
        pcwrite_s   = 1'b1;
      end
      DECODE: begin
        alusrca_s   = 1'b1;
        alusrcb_s   = 2'b10;
        resultsrc_s = 2'b10;
      end
      MEMADR: begin
        alusrcb_s = 2'b01;
      end
      BRANCH: begin
        alusrcb_s   = 2'b01;
        resultsrc_s = 2'b10;
        pcwrite_s   = condex_s;
      end
      MEMRD: begin
        adrsrc_s = 1'b1;
      end
      MEMWR: begin
        adrsrc_s   = 1'b1;
        memwrite_s = condex_s;
      end
      MEMWB: begin
        resultsrc_s = 2'b01;
        regwrite_s  = condex_s;
      end
      EXECUTER: begin
        alucontrol_s = dec_s[3:2];
      end
      EXECUTEI: begin
        alusrcb_s    = 2'b01;
        alucontrol_s = dec_s[3:2];
      end
      ALUWB: begin
        regwrite_s = condex_s & ~nowrite_r;
      end
      default: begin
        pcwrite_s = 1'b0;
      end
    endcase
  end

  // Enables are held low for as long as reset is asserted.
  assign PCWrite    = pcwrite_s  & rst_n;
  assign MemWrite   = memwrite_s & rst_n;
  assign RegWrite   = regwrite_s & rst_n;
  assign IRWrite    = irwrite_s  & rst_n;
  assign AdrSrc     = adrsrc_s;
  assign ResultSrc  = resultsrc_s;
  assign ALUSrcA    = alusrca_s;
  assign ALUSrcB    = alusrcb_s;
  assign ALUControl = alucontrol_s;
  assign ImmSrc     = Op;
  assign RegSrc     = {(Op == 2'b01), (Op == 2'b10)};
  assign Flags      = flags_r;
  assign State      = state_r;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control unit for the ARM-subset processor.
- Sequences one shared ALU, instruction/data memory and register file over 3–5 cycles per instruction.
- Drives the immediate extender's ImmSrc, plus all datapath mux selects and write enables.
- Holds the NZCV flag register and evaluates the condition field.

Parameters:
- RESET_FLAGS, 4'b0000, NZCV value loaded on reset.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- Cond  in  4  Instr[31:28]
- Op  in  2  Instr[27:26]
- Funct  in  6  Instr[25:20]: bit5=I, bits4:1=cmd, bit0=S or L
- ALUFlags  in  4  NZCV result from ALU, current cycle
- PCWrite  out  1  PC register enable
- MemWrite  out  1  data memory write enable
- RegWrite  out  1  register file write enable
- IRWrite  out  1  instruction register enable
- AdrSrc  out  1  memory address mux: 0=PC, 1=ALUResult register
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  out  1  0=RD1 register, 1=PC
- ALUSrcB  out  2  00=RD2 register, 01=ExtImm, 10=constant 4
- ImmSrc  out  2  extender mode, always equal to Op
- RegSrc  out  2  bit0=(Op==10), bit1=(Op==01)
- ALUControl  out  2  00=ADD, 01=SUB, 10=AND, 11=ORR
- Flags  out  4  current NZCV register
- State  out  4  current FSM state encoding, for verification

Behaviour:
- Moore FSM, binary encoding 0–9 in this order: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- Codes 10–15 are illegal and go to FETCH on the next edge.
- Reset (rst_n=0, asynchronous):
  - State=FETCH, Flags=RESET_FLAGS.
  - PCWrite, MemWrite, RegWrite and IRWrite forced 0 while rst_n is low.
  - All other outputs take their FETCH values.
  - First active edge after release performs the FETCH.
- Transitions:
  - FETCH → DECODE.
  - DECODE: Op=01 → MEMADR; Op=00 and Funct[5]=0 → EXECUTER; Op=00 and Funct[5]=1 → EXECUTEI; Op=10 → BRANCH; Op=11 → FETCH (no-op).
  - MEMADR: Funct[0]=1 → MEMRD, else → MEMWR.
  - MEMRD → MEMWB → FETCH.
  - MEMWR → FETCH.
  - EXECUTER/EXECUTEI → ALUWB → FETCH.
  - BRANCH → FETCH.
- Per-state outputs (unlisted selects = 0, unlisted enables = 0):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10.
  - MEMADR and BRANCH: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD; BRANCH also ResultSrc=10 and PCWrite=CondEx.
  - MEMRD: AdrSrc=1.
  - MEMWR: AdrSrc=1, MemWrite=CondEx.
  - MEMWB: ResultSrc=01, RegWrite=CondEx.
  - EXECUTER: ALUSrcB=00, ALU decode active.
  - EXECUTEI: ALUSrcB=01, ALU decode active.
  - ALUWB: ResultSrc=00, RegWrite=CondEx & ~NoWrite.
- ALU decode (EXECUTER/EXECUTEI only), by cmd=Funct[4:1]:
  - 0100 ADD → 00.
  - 0010 SUB → 01.
  - 0000 AND → 10.
  - 1100 ORR → 11.
  - 1010 CMP → 01 with NoWrite=1.
  - Any other cmd → 00 with NoWrite=1.
- NoWrite is registered at the end of EXECUTE and consumed in ALUWB.
- Flag update, end of EXECUTE cycle, only if CondEx=1 and Funct[0]=1:
  - N,Z ← ALUFlags[3:2] for any decoded cmd.
  - C,V ← ALUFlags[1:0] only for ADD, SUB, CMP.
  - Flags are never modified in any other state.
- CondEx, combinational from Cond and registered Flags:
  - 0000 Z; 0001 ~Z; 0010 C; 0011 ~C; 0100 N; 0101 ~N; 0110 V; 0111 ~V.
  - 1000 C&~Z; 1001 ~C|Z; 1010 N==V; 1011 N!=V; 1100 ~Z&(N==V); 1101 Z|(N!=V).
  - 1110 1; 1111 0.
- Cond, Op and Funct are held stable by the IR after FETCH; the block does not latch them.
- Latency: branch 3, STR 4, data-processing 4, LDR 5 cycles, FETCH to FETCH inclusive.
- Reset asserted mid-instruction: immediate return to FETCH, enables drop in the same cycle, Flags reloaded, partial instruction abandoned.

Test Plan:
- Reset then ADD R (Cond=1110, Op=00, Funct=001000) → State 0,1,6,8,0; ALUControl=00 in EXECUTER; RegWrite=1 only in ALUWB; Flags unchanged.
- LDR imm (Op=01, Funct=011001) → State 0,1,2,3,4,0; ImmSrc=01, ALUSrcB=01 in MEMADR; AdrSrc=1 in MEMRD; ResultSrc=01 and RegWrite=1 in MEMWB.
- STR (Funct=011000) → State 0,1,2,5,0; MemWrite=1 for exactly one cycle, in MEMWR.
- CMP (Funct=010101) with ALUFlags=0100 → Flags=0100 after EXECUTER; RegWrite=0 in ALUWB.
- Follow with BEQ (Cond=0000, Op=10) → PCWrite=1 in BRANCH, ImmSrc=10; repeat with Z=0 → PCWrite=0 in BRANCH.
- rst_n low during MEMWR → State=0 and MemWrite=0 asynchronously, Flags=RESET_FLAGS; Op=11 → FETCH, DECODE, FETCH with no enables beyond FETCH.
